ysyx_22041412_sysctl: RTL and testbench

System-instruction controller between execute and the machine CSR unit. Accepts one SYSTEM-opcode instruction at a time from execute, decodes CSR ops, ecall and mret, and drives the CSR unit's en/valid/ready handshake. Returns read data for register writeback and a PC redirect for traps and returns. Unknown CSRs are reported as illegal without touching the CSR unit.

---
 rtl/ysyx_22041412_sysctl_pkg.sv | 47 ++++
 rtl/ysyx_22041412_sysdec.sv | 41 ++++
 rtl/ysyx_22041412_sysctl.sv | 138 +++++++++++++
 tb/tb_ysyx_22041412_sysctl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_sysctl_pkg.sv
// Shared constants and types for the SYSTEM-instruction controller:
// opcode, fixed ecall/mret encodings, CSR addresses, CSR index map,
// func3 codes and the controller FSM states.
package ysyx_22041412_sysctl_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Index presented to the CSR unit on csr_addr.
  typedef enum logic [2:0] {
    CSR_MRET    = 3'd0,
    CSR_ECALL   = 3'd1,
    CSR_MSTATUS = 3'd2,
    CSR_MTVEC   = 3'd3,
    CSR_MEPC    = 3'd4,
    CSR_MCAUSE  = 3'd5
  } csr_idx_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // ecall and mret redirect fetch instead of writing rd.
  function automatic logic is_priv(input csr_idx_e idx);
    return (idx == CSR_MRET) || (idx == CSR_ECALL);
  endfunction

endpackage

// File: rtl/ysyx_22041412_sysdec.sv
// Combinational decode of a SYSTEM instruction into CSR index, func3,
// operand select (register vs. zero-extended immediate), rd and illegal.
module ysyx_22041412_sysdec
  import ysyx_22041412_sysctl_pkg::*;
(
  input  logic [31:0] inst,
  output csr_idx_e    idx,
  output logic [2:0]  func3,
  output logic        use_imm,
  output logic [4:0]  rd,
  output logic        illegal
);

  assign func3   = inst[14:12];
  assign rd      = inst[11:7];
  assign use_imm = inst[14];

  // Map the encoding onto a CSR index; anything unrecognised is illegal.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    idx     = CSR_MRET;
    illegal = 1'b0;
    if (func3 == F3_PRIV) begin
      if (inst == INST_ECALL)     idx = CSR_ECALL;
      else if (inst == INST_MRET) idx = CSR_MRET;
      else                        illegal = 1'b1;
    end else if (func3 == 3'b100) begin
      illegal = 1'b1;
    end else begin
      case (inst[31:20])
        CSR_ADDR_MSTATUS: idx = CSR_MSTATUS;
        CSR_ADDR_MTVEC:   idx = CSR_MTVEC;
        CSR_ADDR_MEPC:    idx = CSR_MEPC;
        CSR_ADDR_MCAUSE:  idx = CSR_MCAUSE;
        default:          illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041412_sysctl.sv
// SYSTEM-instruction controller: accepts one instruction from execute,
// runs the REQ/ACK handshake with the CSR unit and returns writeback or
// redirect results. Optional macro SYSCTL_TRACE_EN adds a retired-op
// counter and a per-completion trace print.
module ysyx_22041412_sysctl
  import ysyx_22041412_sysctl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal,
  output logic            csr_en,
  output logic [XLEN-1:0] csr_pc,
  output logic [2:0]      csr_addr,
  output logic [2:0]      csr_func3,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_valid,
  input  logic            csr_ready
);

  state_e   state, state_next;
  csr_idx_e dec_idx, idx_q;
  logic [2:0]      dec_func3;
  logic            dec_use_imm, dec_illegal, illegal_q;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] rdata_q;

  ysyx_22041412_sysdec u_dec (
    .inst    (inst),
    .idx     (dec_idx),
    .func3   (dec_func3),
    .use_imm (dec_use_imm),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  wire accept = (state == S_IDLE) && in_valid;

  // State register; rst from any state abandons the operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every register
    // samples values from before the edge, independent of block order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    csr_en     = 1'b0;
    csr_valid  = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = dec_illegal ? S_DONE : S_REQ;
      end
      S_REQ: begin
        csr_en = 1'b1;
        if (csr_ready) state_next = S_ACK;
      end
      S_ACK: begin
        csr_en     = 1'b1;
        csr_valid  = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields latch at acceptance and stay put until the next one;
  // read data is captured when the CSR unit signals ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_pc    <= '0;
      csr_addr  <= '0;
      csr_func3 <= '0;
      csr_wdata <= '0;
      idx_q     <= CSR_MRET;
      illegal_q <= 1'b0;
      wb_rd     <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        csr_pc    <= pc;
        csr_addr  <= dec_idx;
        csr_func3 <= dec_func3;
        csr_wdata <= dec_use_imm ? {{(XLEN-5){1'b0}}, inst[19:15]} : rs1_data;
        idx_q     <= dec_idx;
        illegal_q <= dec_illegal;
        wb_rd     <= dec_rd;
      end
      if (state == S_REQ && csr_ready) rdata_q <= csr_rdata;
    end
  end

  // Result flags only show while the completion is offered.
  assign wb_en       = out_valid && !illegal_q && !is_priv(idx_q) && (wb_rd != 5'd0);
  assign redirect    = out_valid && !illegal_q && is_priv(idx_q);
  assign illegal     = out_valid && illegal_q;
  assign wb_data     = rdata_q;
  assign redirect_pc = rdata_q;

`ifdef SYSCTL_TRACE_EN
  logic [63:0] retired_cnt;

  // Count and log every completion handed to writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (out_valid && out_ready) begin
      retired_cnt <= retired_cnt + 64'd1;
      $display("sysctl retire #%0d pc=%h kind=%s idx=%0d wb_data=%h redirect_pc=%h",
               retired_cnt, csr_pc,
               illegal_q ? "illegal" : (is_priv(idx_q) ? "priv" : "csr"),
               idx_q, wb_data, redirect_pc);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041412_sysctl.sv
// Directed bench for ysyx_22041412_sysctl with a behavioural CSR unit.
module tb_ysyx_22041412_sysctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data;
  logic        out_valid, out_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        illegal;
  logic        csr_en;
  logic [63:0] csr_pc;
  logic [2:0]  csr_addr, csr_func3;
  logic [63:0] csr_wdata, csr_rdata;
  logic        csr_valid, csr_ready;

  int checks = 0;
  int errors = 0;

  ysyx_22041412_sysctl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc), .rs1_data(rs1_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal),
    .csr_en(csr_en), .csr_pc(csr_pc), .csr_addr(csr_addr), .csr_func3(csr_func3),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_valid(csr_valid), .csr_ready(csr_ready)
  );

  always #5 clk = ~clk;

  // Behavioural CSR unit: ready while enabled until the commit strobe.
  logic        ready_gate;
  logic [63:0] mstatus = 64'ha0000_1800;
  logic [63:0] mtvec   = 64'h0;
  logic [63:0] mepc    = 64'h0;
  logic [63:0] mcause  = 64'h0;
  int en_cnt = 0, valid_cnt = 0, orphan_cnt = 0;

  assign csr_ready = csr_en & ~csr_valid & ready_gate;

  always_comb begin
    csr_rdata = 64'h0;
    case (csr_addr)
      3'd0: csr_rdata = mepc;
      3'd1: csr_rdata = mtvec;
      3'd2: csr_rdata = mstatus;
      3'd3: csr_rdata = mtvec;
      3'd4: csr_rdata = mepc;
      3'd5: csr_rdata = mcause;
      default: csr_rdata = 64'h0;
    endcase
  end

  function automatic logic [63:0] csr_apply(input logic [63:0] old, input logic [2:0] f3,
                                            input logic [63:0] w);
    case (f3[1:0])
      2'b01:   return w;
      2'b10:   return old | w;
      2'b11:   return old & ~w;
      default: return old;
    endcase
  endfunction

  always @(posedge clk) begin
    if (csr_en) en_cnt++;
    if (csr_valid) valid_cnt++;
    if (csr_valid && !csr_en) orphan_cnt++;
    if (csr_valid) begin
      case (csr_addr)
        3'd1: begin mepc <= csr_pc; mcause <= 64'hb; end
        3'd2: mstatus <= csr_apply(mstatus, csr_func3, csr_wdata);
        3'd3: mtvec   <= csr_apply(mtvec,   csr_func3, csr_wdata);
        3'd4: mepc    <= csr_apply(mepc,    csr_func3, csr_wdata);
        3'd5: mcause  <= csr_apply(mcause,  csr_func3, csr_wdata);
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".in_ready"},    in_ready,    1);
    check({tag, ".out_valid"},   out_valid,   0);
    check({tag, ".csr_en"},      csr_en,      0);
    check({tag, ".csr_valid"},   csr_valid,   0);
    check({tag, ".wb_en"},       wb_en,       0);
    check({tag, ".wb_rd"},       wb_rd,       0);
    check({tag, ".wb_data"},     wb_data,     0);
    check({tag, ".redirect"},    redirect,    0);
    check({tag, ".redirect_pc"}, redirect_pc, 0);
    check({tag, ".illegal"},     illegal,     0);
    check({tag, ".csr_pc"},      csr_pc,      0);
    check({tag, ".csr_addr"},    csr_addr,    0);
    check({tag, ".csr_func3"},   csr_func3,   0);
    check({tag, ".csr_wdata"},   csr_wdata,   0);
  endtask

  // Present one instruction; lat = edges after acceptance until out_valid.
  task automatic issue(input string tag, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] r, output int lat);
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    inst = i; pc = p; rs1_data = r; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  // Hold out_ready low for 'hold' cycles checking stability, then retire.
  task automatic complete(input string tag, input int hold);
    logic [63:0] d0, pc0;
    logic        e0, r0;
    d0 = wb_data; pc0 = redirect_pc; e0 = wb_en; r0 = redirect;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold.out_valid"}, out_valid, 1);
      check({tag, ".hold.in_ready"},  in_ready,  0);
      check({tag, ".hold.wb_data"},   wb_data,   d0);
      check({tag, ".hold.wb_en"},     wb_en,     e0);
      check({tag, ".hold.redirect"},  redirect,  r0);
      check({tag, ".hold.rpc"},       redirect_pc, pc0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".retired.out_valid"}, out_valid, 0);
    check({tag, ".retired.in_ready"},  in_ready,  1);
  endtask

  initial begin
    int lat, v0, e0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0; rs1_data = '0;
    ready_gate = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // csrrw x5, mtvec, x6; busy-time in_valid must be ignored
    v0 = valid_cnt;
    issue("csrrw", 32'h3053_12F3, 64'h8000_0000, 64'h8000_0100, lat);
    check("csrrw.lat",       lat,       2);
    check("csrrw.csr_addr",  csr_addr,  3);
    check("csrrw.csr_func3", csr_func3, 1);
    check("csrrw.csr_wdata", csr_wdata, 64'h8000_0100);
    check("csrrw.wb_en",     wb_en,     1);
    check("csrrw.wb_rd",     wb_rd,     5);
    check("csrrw.wb_data",   wb_data,   0);
    check("csrrw.redirect",  redirect,  0);
    check("csrrw.illegal",   illegal,   0);
    @(negedge clk);
    inst = 32'h3004_6073; in_valid = 1'b1;
    complete("csrrw", 5);
    check("csrrw.valid_pulses", valid_cnt - v0, 1);
    check("csrrw.mtvec",        mtvec, 64'h8000_0100);

    // csrrs x7, mtvec, x0 reads mtvec back
    issue("rdmtvec", 32'h3050_23F3, 64'h8000_0004, 64'h0, lat);
    check("rdmtvec.wb_en",   wb_en,   1);
    check("rdmtvec.wb_rd",   wb_rd,   7);
    check("rdmtvec.wb_data", wb_data, 64'h8000_0100);
    check("rdmtvec.func3",   csr_func3, 2);
    complete("rdmtvec", 0);

    // csrrsi x0, mstatus, 0x8
    issue("csrrsi", 32'h3004_6073, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    check("csrrsi.lat",       lat,       2);
    check("csrrsi.csr_wdata", csr_wdata, 64'h8);
    check("csrrsi.csr_func3", csr_func3, 6);
    check("csrrsi.wb_en",     wb_en,     0);
    check("csrrsi.wb_data",   wb_data,   64'ha0000_1800);
    complete("csrrsi", 0);
    check("csrrsi.mstatus",   mstatus,   64'ha0000_1808);

    // ecall
    issue("ecall", 32'h0000_0073, 64'h8000_0040, 64'h0, lat);
    check("ecall.lat",         lat,         2);
    check("ecall.redirect",    redirect,    1);
    check("ecall.redirect_pc", redirect_pc, 64'h8000_0100);
    check("ecall.wb_en",       wb_en,       0);
    check("ecall.csr_addr",    csr_addr,    1);
    check("ecall.csr_pc",      csr_pc,      64'h8000_0040);
    complete("ecall", 0);
    check("ecall.mepc",   mepc,   64'h8000_0040);
    check("ecall.mcause", mcause, 64'hb);

    // mret
    v0 = valid_cnt;
    issue("mret", 32'h3020_0073, 64'h8000_0200, 64'h0, lat);
    check("mret.redirect",    redirect,    1);
    check("mret.redirect_pc", redirect_pc, 64'h8000_0040);
    check("mret.wb_en",       wb_en,       0);
    check("mret.csr_addr",    csr_addr,    0);
    complete("mret", 0);
    check("mret.valid_pulses", valid_cnt - v0, 1);

    // unmapped CSR and reserved func3 are illegal without touching the CSR unit
    e0 = en_cnt;
    issue("ill7c0", 32'h7C01_10F3, 64'h8000_0300, 64'h1234, lat);
    check("ill7c0.lat",      lat,      0);
    check("ill7c0.illegal",  illegal,  1);
    check("ill7c0.wb_en",    wb_en,    0);
    check("ill7c0.redirect", redirect, 0);
    complete("ill7c0", 0);
    issue("illf3", 32'h3004_4073, 64'h8000_0304, 64'h0, lat);
    check("illf3.lat",     lat,     0);
    check("illf3.illegal", illegal, 1);
    complete("illf3", 0);
    check("illegal.csr_en_cycles", en_cnt - e0, 0);

    // reset while waiting in REQ abandons the write
    ready_gate = 1'b0;
    v0 = valid_cnt;
    @(negedge clk);
    inst = 32'h3053_12F3; pc = 64'h8000_0400; rs1_data = 64'hDEAD; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("abort.req.csr_en",   csr_en,   1);
    check("abort.req.in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 check("abort.stall.csr_en",    csr_en,    1);
    check("abort.stall.csr_valid",    csr_valid, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("abort");
    @(negedge clk) begin rst = 1'b0; ready_gate = 1'b1; end
    repeat (2) @(posedge clk);
    #1 check("abort.after.out_valid", out_valid, 0);
    check("abort.after.csr_en",       csr_en,    0);
    check("abort.valid_pulses",       valid_cnt - v0, 0);
    check("abort.mtvec",              mtvec, 64'h8000_0100);
    issue("recover", 32'h3050_23F3, 64'h8000_0404, 64'h0, lat);
    check("recover.lat",     lat,     2);
    check("recover.wb_data", wb_data, 64'h8000_0100);
    complete("recover", 0);

    check("csr_valid_without_en", orphan_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
